// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: cascadable up/down BCD counter with programmable maximum,
// preset load, terminal count for zero-latency chaining and optional one-shot countdown.
module bcd_mod_counter #(
   parameter int DIGITS   = 2,
   parameter int MAX_VAL  = 59,
   parameter bit ONE_SHOT = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clr,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   input  logic                en,
   input  logic                up_dn,
   output logic [4*DIGITS-1:0] count_out,
   output logic                tc,
   output logic                wrap,
   output logic                zero,
   output logic                done,
   output logic                load_err
);
   localparam int W = 4 * DIGITS;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

   logic [W-1:0] cnt_q, cnt_d, inc_v, dec_v;
   logic         wrap_q, wrap_d, done_q, done_d, err_q, err_d;
   logic         carry, borrow, digits_ok, at_max, at_zero, load_ok;

   assign at_max  = cnt_q == MAX_BCD;
   assign at_zero = cnt_q == '0;
   // With every digit legal, BCD ordering matches plain unsigned ordering.
   assign load_ok = digits_ok && (load_val <= MAX_BCD);

   always_comb begin
      inc_v     = cnt_q;
      dec_v     = cnt_q;
      carry     = 1'b1;
      borrow    = 1'b1;
      digits_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) inc_v[4*i +: 4] = (cnt_q[4*i +: 4] == 4'd9) ? 4'd0 : cnt_q[4*i +: 4] + 4'd1;
         if (borrow) dec_v[4*i +: 4] = (cnt_q[4*i +: 4] == 4'd0) ? 4'd9 : cnt_q[4*i +: 4] - 4'd1;
         carry     = carry && (cnt_q[4*i +: 4] == 4'd9);
         borrow    = borrow && (cnt_q[4*i +: 4] == 4'd0);
         digits_ok = digits_ok && (load_val[4*i +: 4] <= 4'd9);
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      done_d = done_q;
      err_d  = 1'b0;
      if (clr) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (load) begin
         cnt_d  = load_ok ? load_val : cnt_q;
         done_d = load_ok ? 1'b0 : done_q;
         err_d  = !load_ok;
      end else if (en && up_dn) begin
         cnt_d  = at_max ? '0 : inc_v;
         wrap_d = at_max;
      end else if (en) begin
         cnt_d  = at_zero ? (ONE_SHOT ? '0 : MAX_BCD) : dec_v;
         wrap_d = at_zero && !ONE_SHOT;
         done_d = done_q || (ONE_SHOT && (at_zero || dec_v == '0));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign tc        = en && !clr && !load && ((up_dn && at_max) || (!up_dn && at_zero && !ONE_SHOT));
   assign count_out = cnt_q;
   assign wrap      = wrap_q;
   assign zero      = at_zero;
   assign done      = done_q;
   assign load_err  = err_q;
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: directed checks of seconds/minutes cascade, hours load
// validation and one-shot timer instances.
module tb_bcd_mod_counter;
   logic clk = 1'b0, reset = 1'b1;
   int   n_cmp = 0, n_err = 0;

   logic       s_clr = 0, s_load = 0, s_en = 0, s_up = 1;
   logic [7:0] s_val = 0, s_cnt;
   logic       s_tc, s_wrap, s_zero, s_done, s_err;
   logic       m_load = 0;
   logic [7:0] m_val = 0, m_cnt;
   logic       m_tc, m_wrap, m_zero, m_done, m_err;
   logic       h_clr = 0, h_load = 0, h_en = 0, h_up = 1;
   logic [7:0] h_val = 0, h_cnt;
   logic       h_tc, h_wrap, h_zero, h_done, h_err;
   logic       t_load = 0, t_en = 0, t_up = 0;
   logic [7:0] t_val = 0, t_cnt;
   logic       t_tc, t_wrap, t_zero, t_done, t_err;

   always #5 clk = ~clk;

   bcd_mod_counter #(.DIGITS(2), .MAX_VAL(59), .ONE_SHOT(1'b0)) u_sec (
      .clk(clk), .reset(reset), .clr(s_clr), .load(s_load), .load_val(s_val), .en(s_en),
      .up_dn(s_up), .count_out(s_cnt), .tc(s_tc), .wrap(s_wrap), .zero(s_zero),
      .done(s_done), .load_err(s_err));

   bcd_mod_counter #(.DIGITS(2), .MAX_VAL(59), .ONE_SHOT(1'b0)) u_min (
      .clk(clk), .reset(reset), .clr(1'b0), .load(m_load), .load_val(m_val), .en(s_tc),
      .up_dn(s_up), .count_out(m_cnt), .tc(m_tc), .wrap(m_wrap), .zero(m_zero),
      .done(m_done), .load_err(m_err));

   bcd_mod_counter #(.DIGITS(2), .MAX_VAL(23), .ONE_SHOT(1'b0)) u_hr (
      .clk(clk), .reset(reset), .clr(h_clr), .load(h_load), .load_val(h_val), .en(h_en),
      .up_dn(h_up), .count_out(h_cnt), .tc(h_tc), .wrap(h_wrap), .zero(h_zero),
      .done(h_done), .load_err(h_err));

   bcd_mod_counter #(.DIGITS(2), .MAX_VAL(99), .ONE_SHOT(1'b1)) u_tmr (
      .clk(clk), .reset(reset), .clr(1'b0), .load(t_load), .load_val(t_val), .en(t_en),
      .up_dn(t_up), .count_out(t_cnt), .tc(t_tc), .wrap(t_wrap), .zero(t_zero),
      .done(t_done), .load_err(t_err));

   function automatic logic [7:0] bcd(input int k);
      return 8'((k / 10) * 16 + k % 10);
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_cnt", s_cnt, 8'h00);
      chk("rst_wrap", s_wrap, 0);
      chk("rst_zero", s_zero, 1);
      chk("rst_done", t_done, 0);
      chk("rst_err", h_err, 0);

      // Up count 00..59 then wrap, minutes follow via tc
      s_en = 1;
      s_up = 1;
      #1;
      for (int k = 0; k < 60; k++) begin
         chk("up_cnt", s_cnt, bcd(k));
         chk("up_tc", s_tc, k == 59);
         chk("up_zero", s_zero, k == 0);
         step();
         chk("up_wrap", s_wrap, k == 59);
      end
      chk("up_end", s_cnt, 8'h00);
      chk("casc_min", m_cnt, 8'h01);

      // Down count wraps 00->59 and borrows through 10->09
      s_up = 0;
      #1 chk("dn_tc", s_tc, 1);
      step();
      chk("dn_wrap_cnt", s_cnt, 8'h59);
      chk("dn_wrap", s_wrap, 1);
      chk("dn_min", m_cnt, 8'h00);
      for (int k = 58; k >= 9; k--) begin
         step();
         chk("dn_cnt", s_cnt, bcd(k));
         chk("dn_wrap0", s_wrap, 0);
      end
      s_en = 0;
      step();
      chk("hold_cnt", s_cnt, 8'h09);
      chk("hold_wrap", s_wrap, 0);

      // Hours: load validation and priorities
      h_load = 1; h_val = 8'h25;
      step();
      chk("h25_err", h_err, 1);
      chk("h25_cnt", h_cnt, 8'h00);
      h_load = 0;
      step();
      chk("h_err_pulse", h_err, 0);
      h_load = 1; h_val = 8'h1A;
      step();
      chk("h1a_err", h_err, 1);
      chk("h1a_cnt", h_cnt, 8'h00);
      h_val = 8'h23;
      step();
      chk("h23_cnt", h_cnt, 8'h23);
      chk("h23_err", h_err, 0);
      h_val = 8'h10; h_en = 1; h_up = 1;
      #1 chk("h_tc_gate", h_tc, 0);
      step();
      chk("h_load_wins", h_cnt, 8'h10);
      h_en = 0; h_val = 8'h23;
      step();
      h_load = 0; h_en = 1;
      #1 chk("h_tc", h_tc, 1);
      step();
      chk("h_wrap_cnt", h_cnt, 8'h00);
      chk("h_wrap", h_wrap, 1);
      step();
      chk("h_inc", h_cnt, 8'h01);
      h_clr = 1; h_load = 1; h_val = 8'h05;
      step();
      chk("h_clr_wins", h_cnt, 8'h00);
      h_clr = 0; h_load = 0; h_en = 0;

      // One-shot timer countdown
      t_load = 1; t_val = 8'h03;
      step();
      chk("t_load", t_cnt, 8'h03);
      t_load = 0; t_en = 1; t_up = 0;
      step();
      chk("t_02", t_cnt, 8'h02);
      step();
      chk("t_01", t_cnt, 8'h01);
      chk("t_done0", t_done, 0);
      step();
      chk("t_00", t_cnt, 8'h00);
      chk("t_done", t_done, 1);
      chk("t_wrap", t_wrap, 0);
      chk("t_tc", t_tc, 0);
      step();
      chk("t_hold", t_cnt, 8'h00);
      chk("t_hold_wrap", t_wrap, 0);
      t_up = 1;
      step();
      chk("t_up_cnt", t_cnt, 8'h01);
      chk("t_up_done", t_done, 1);
      t_en = 0; t_load = 1; t_val = 8'h05;
      step();
      chk("t_reload", t_cnt, 8'h05);
      chk("t_reload_done", t_done, 0);
      t_load = 0;

      // Cascade 59:59 -> 00:00
      s_load = 1; s_val = 8'h59; m_load = 1; m_val = 8'h59;
      step();
      chk("c_s59", s_cnt, 8'h59);
      chk("c_m59", m_cnt, 8'h59);
      s_load = 0; m_load = 0; s_en = 1; s_up = 1;
      #1 chk("c_tc", s_tc, 1);
      step();
      chk("c_s00", s_cnt, 8'h00);
      chk("c_m00", m_cnt, 8'h00);
      chk("c_mwrap", m_wrap, 1);
      s_en = 0;

      // Asynchronous reset between edges
      s_load = 1; s_val = 8'h37;
      step();
      s_load = 0;
      chk("a_37", s_cnt, 8'h37);
      #2 reset = 1;
      #1 chk("a_cnt", s_cnt, 8'h00);
      chk("a_zero", s_zero, 1);
      #1 reset = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
